// File: rtl/wshb_arb_pkg.sv
// Shared types and helpers for the two-master SDRAM Wishbone arbiter.
package wshb_arb_pkg;

    localparam int NB_MASTERS = 2;
    localparam int MIDX_W     = $clog2(NB_MASTERS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    // Round-robin pick: on a tie the master that was not served last wins.
    function automatic arb_state_t arb_pick(input logic req0, input logic req1,
                                            input logic [MIDX_W-1:0] last_served);
        arb_state_t pick;
        if (req0 && req1) begin
            pick = (last_served == 1'b1) ? GNT0 : GNT1;
        end else if (req0) begin
            pick = GNT0;
        end else if (req1) begin
            pick = GNT1;
        end else begin
            pick = IDLE;
        end
        return pick;
    endfunction

endpackage

// File: rtl/wshb_if.sv
// Classic Wishbone bus bundle with master and slave views.
interface wshb_if #(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_W     = 32
);
    localparam int DW = DATA_BYTES * 8;

    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [ADDR_W-1:0]     adr;
    logic [DW-1:0]         dat_ms;
    logic [DW-1:0]         dat_sm;
    logic [DATA_BYTES-1:0] sel;
    logic [2:0]            cti;
    logic [1:0]            bte;
    logic                  ack;
    logic                  err;
    logic                  rty;

    modport master (
        output cyc, stb, we, adr, dat_ms, sel, cti, bte,
        input  dat_sm, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
        output dat_sm, ack, err, rty
    );

endinterface

// File: rtl/wshb_arb_watchdog.sv
// Stall watchdog for the granted bus cycle: abort pulse and saturating abort counter.
module wshb_arb_watchdog #(
    parameter int TIMEOUT = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       active,
    input  logic       stb,
    input  logic       term,
    output logic       abort,
    output logic [7:0] abort_cnt
);
    localparam int              WD_W     = $clog2(TIMEOUT) + 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_ONE   = WD_W'(1);

    logic [WD_W-1:0] cnt_q;
    logic [WD_W-1:0] cnt_d;
    logic [7:0]      abort_cnt_q;
    logic [7:0]      abort_cnt_d;

    // Fires in the stalled strobe cycle that would reach the limit.
    assign abort     = active & stb & ~term & (cnt_q == WD_LIMIT);
    assign abort_cnt = abort_cnt_q;

    // Next counter values: stall counter and saturating abort tally.
    always_comb begin
        if (!active || term || abort) begin
            cnt_d = '0;
        end else if (stb) begin
            cnt_d = cnt_q + WD_ONE;
        end else begin
            cnt_d = cnt_q;
        end

        if (abort && (abort_cnt_q != 8'hFF)) begin
            abort_cnt_d = abort_cnt_q + 8'd1;
        end else begin
            abort_cnt_d = abort_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            abort_cnt_q <= 8'd0;
        end else begin
            cnt_q       <= cnt_d;
            abort_cnt_q <= abort_cnt_d;
        end
    end

endmodule

// File: rtl/wshb_sdram_arbiter.sv
// Round-robin arbiter sharing the SDRAM Wishbone slave between the video reader (m0)
// and the frame writer (m1); the grant is held for a whole cyc transaction.
module wshb_sdram_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int TIMEOUT     = 256,
    parameter bit M0_PRIO_RST = 1'b1
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    wshb_if.slave      wshb_ifs0,
    wshb_if.slave      wshb_ifs1,
    wshb_if.master     wshb_ifm,
    output logic       busy,
    output logic [7:0] abort_cnt
);
    arb_state_t        state_q;
    arb_state_t        state_d;
    logic [MIDX_W-1:0] last_served_q;
    logic [MIDX_W-1:0] last_served_d;
    logic              gnt_cyc_s;
    logic              gnt_stb_s;
    logic              term_s;
    logic              abort_s;

    // Handshake of whichever master currently owns the bus.
    always_comb begin
        case (state_q)
            GNT0: begin
                gnt_cyc_s = wshb_ifs0.cyc;
                gnt_stb_s = wshb_ifs0.stb;
            end
            GNT1: begin
                gnt_cyc_s = wshb_ifs1.cyc;
                gnt_stb_s = wshb_ifs1.stb;
            end
            default: begin
                gnt_cyc_s = 1'b0;
                gnt_stb_s = 1'b0;
            end
        endcase
    end

    assign term_s = wshb_ifm.ack | wshb_ifm.err | wshb_ifm.rty;
    assign busy   = (state_q != IDLE);

    wshb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .active    (state_q != IDLE),
        .stb       (gnt_stb_s),
        .term      (term_s),
        .abort     (abort_s),
        .abort_cnt (abort_cnt)
    );

    // Next grant: arbitrate only from IDLE so two grants are always separated.
    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        case (state_q)
            IDLE: begin
                state_d = arb_pick(wshb_ifs0.cyc, wshb_ifs1.cyc, last_served_q);
                if (state_d == GNT0) begin
                    last_served_d = 1'b0;
                end else if (state_d == GNT1) begin
                    last_served_d = 1'b1;
                end else begin
                    last_served_d = last_served_q;
                end
            end
            GNT0, GNT1: begin
                if (!gnt_cyc_s || abort_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Arbiter state register.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q       <= IDLE;
            last_served_q <= M0_PRIO_RST;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
        end
    end

    // Request path to the SDRAM slave; an abort kills cyc/stb in its own cycle.
    always_comb begin
        wshb_ifm.cyc    = 1'b0;
        wshb_ifm.stb    = 1'b0;
        wshb_ifm.we     = 1'b0;
        wshb_ifm.adr    = '0;
        wshb_ifm.dat_ms = '0;
        wshb_ifm.sel    = '0;
        wshb_ifm.cti    = 3'b000;
        wshb_ifm.bte    = 2'b00;
        case (state_q)
            GNT0: begin
                wshb_ifm.cyc    = wshb_ifs0.cyc & ~abort_s;
                wshb_ifm.stb    = wshb_ifs0.stb & ~abort_s;
                wshb_ifm.we     = wshb_ifs0.we;
                wshb_ifm.adr    = wshb_ifs0.adr;
                wshb_ifm.dat_ms = wshb_ifs0.dat_ms;
                wshb_ifm.sel    = wshb_ifs0.sel;
                wshb_ifm.cti    = wshb_ifs0.cti;
                wshb_ifm.bte    = wshb_ifs0.bte;
            end
            GNT1: begin
                wshb_ifm.cyc    = wshb_ifs1.cyc & ~abort_s;
                wshb_ifm.stb    = wshb_ifs1.stb & ~abort_s;
                wshb_ifm.we     = wshb_ifs1.we;
                wshb_ifm.adr    = wshb_ifs1.adr;
                wshb_ifm.dat_ms = wshb_ifs1.dat_ms;
                wshb_ifm.sel    = wshb_ifs1.sel;
                wshb_ifm.cti    = wshb_ifs1.cti;
                wshb_ifm.bte    = wshb_ifs1.bte;
            end
            default: begin
                wshb_ifm.cyc    = 1'b0;
                wshb_ifm.stb    = 1'b0;
            end
        endcase
    end

    // Response path: terminations only reach the owner, read data goes to both.
    always_comb begin
        wshb_ifs0.dat_sm = wshb_ifm.dat_sm;
        wshb_ifs1.dat_sm = wshb_ifm.dat_sm;
        wshb_ifs0.ack    = (state_q == GNT0) & wshb_ifm.ack;
        wshb_ifs0.err    = (state_q == GNT0) & (wshb_ifm.err | abort_s);
        wshb_ifs0.rty    = (state_q == GNT0) & wshb_ifm.rty;
        wshb_ifs1.ack    = (state_q == GNT1) & wshb_ifm.ack;
        wshb_ifs1.err    = (state_q == GNT1) & (wshb_ifm.err | abort_s);
        wshb_ifs1.rty    = (state_q == GNT1) & wshb_ifm.rty;
    end

endmodule

// File: tb/tb_wshb_sdram_arbiter.sv
// Randomised and directed bench for wshb_sdram_arbiter against a cycle-level ownership model.
module tb_wshb_sdram_arbiter;
    localparam int TOUT = 16;

    localparam int B_MCYC  = 16;
    localparam int B_MSTB  = 15;
    localparam int B_S0ACK = 14;
    localparam int B_S0ERR = 13;
    localparam int B_S1ACK = 11;
    localparam int B_S1ERR = 10;
    localparam int B_BUSY  = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       busy;
    logic [7:0] abort_cnt;

    always #5 clk = ~clk;

    wshb_if #(.DATA_BYTES(4)) s0 ();
    wshb_if #(.DATA_BYTES(4)) s1 ();
    wshb_if #(.DATA_BYTES(4)) m ();

    wshb_sdram_arbiter #(
        .TIMEOUT     (TOUT),
        .M0_PRIO_RST (1'b1)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .wshb_ifs0 (s0),
        .wshb_ifs1 (s1),
        .wshb_ifm  (m),
        .busy      (busy),
        .abort_cnt (abort_cnt)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: bus owner (0 none, 1 = m0, 2 = m1), last master served, stall count, aborts.
    int own  = 0;
    int last = 2;
    int wd   = 0;
    int ab   = 0;

    logic [16:0]  oc, ec;
    logic [137:0] od, ed;

    task automatic drive_m(input int idx, input logic cyc, input logic stb, input logic we,
                           input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [2:0] cti);
        if (idx == 0) begin
            s0.cyc = cyc; s0.stb = stb; s0.we = we; s0.adr = adr;
            s0.dat_ms = dat; s0.sel = sel; s0.cti = cti; s0.bte = 2'b00;
        end else begin
            s1.cyc = cyc; s1.stb = stb; s1.we = we; s1.adr = adr;
            s1.dat_ms = dat; s1.sel = sel; s1.cti = cti; s1.bte = 2'b01;
        end
    endtask

    task automatic drive_s(input logic ack, input logic err, input logic rty, input logic [31:0] dat);
        m.ack = ack; m.err = err; m.rty = rty; m.dat_sm = dat;
    endtask

    // One clock: sample DUT and model at negedge, advance model, return at posedge+1.
    task automatic cycle(output logic [16:0] o_c, output logic [16:0] e_c,
                         output logic [137:0] o_d, output logic [137:0] e_d);
        logic       cy, sb, tm, abt;
        logic [73:0] fwd;
        @(negedge clk);
        cy  = (own == 1) ? s0.cyc : (own == 2) ? s1.cyc : 1'b0;
        sb  = (own == 1) ? s0.stb : (own == 2) ? s1.stb : 1'b0;
        tm  = m.ack | m.err | m.rty;
        abt = (own != 0) && sb && !tm && (wd == TOUT - 1);
        fwd = '0;
        if (own == 1) fwd = {s0.we, s0.adr, s0.dat_ms, s0.sel, s0.cti, s0.bte};
        if (own == 2) fwd = {s1.we, s1.adr, s1.dat_ms, s1.sel, s1.cti, s1.bte};
        e_c = {cy & ~abt, sb & ~abt,
               (own == 1) & m.ack, (own == 1) & (m.err | abt), (own == 1) & m.rty,
               (own == 2) & m.ack, (own == 2) & (m.err | abt), (own == 2) & m.rty,
               (own != 0), 8'(ab)};
        e_d = {fwd, m.dat_sm, m.dat_sm};
        o_c = {m.cyc, m.stb, s0.ack, s0.err, s0.rty, s1.ack, s1.err, s1.rty, busy, abort_cnt};
        o_d = {m.we, m.adr, m.dat_ms, m.sel, m.cti, m.bte, s0.dat_sm, s1.dat_sm};
        if (!rst_n) begin
            own = 0; last = 2; wd = 0; ab = 0;
        end else begin
            wd = (own == 0 || tm || abt) ? 0 : (sb ? wd + 1 : wd);
            if (abt) ab = (ab < 255) ? ab + 1 : 255;
            if (own == 0) begin
                if (s0.cyc && s1.cyc) own = (last == 2) ? 1 : 2;
                else if (s0.cyc)      own = 1;
                else if (s1.cyc)      own = 2;
                if (own != 0) last = own;
            end else if (!cy || abt) begin
                own = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic release_all();
        drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
        drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
        drive_s(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic apply_reset();
        release_all();
        rst_n = 1'b0;
        cycle(oc, ec, od, ed);
        cycle(oc, ec, od, ed);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycle(oc, ec, od, ed);
        checks++;
        if ({oc, od} !== {ec, ed}) begin
            errors++; $display("FAIL reset_hold ctl act=%h exp=%h data act=%h exp=%h", oc, ec, od, ed);
        end
        rst_n = 1'b1;
        cycle(oc, ec, od, ed);
        checks++;
        if ({oc[B_MCYC], oc[B_BUSY], oc[7:0]} !== 10'd0) begin
            errors++; $display("FAIL reset_state act=%h exp=0", {oc[B_MCYC], oc[B_BUSY], oc[7:0]});
        end
    endtask

    task automatic test_burst_m0();
        int a0 = 0, a1 = 0, first = -1;
        drive_m(0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 3'b010);
        for (int k = 0; k < 6; k++) begin
            drive_s(k >= 1 && k <= 4, 1'b0, 1'b0, $urandom);
            if (k == 4) s0.cti = 3'b111;
            if (k == 5) drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
            cycle(oc, ec, od, ed);
            checks++;
            if ({oc, od} !== {ec, ed}) begin
                errors++; $display("FAIL burst_m0 k=%0d ctl act=%h exp=%h data act=%h exp=%h", k, oc, ec, od, ed);
            end
            if (oc[B_MCYC] && first < 0) first = k;
            a0 += int'(oc[B_S0ACK]);
            a1 += int'(oc[B_S1ACK]);
        end
        checks++;
        if (first !== 1 || a0 !== 4 || a1 !== 0) begin
            errors++; $display("FAIL burst_m0_counts latency=%0d acks0=%0d acks1=%0d exp 1/4/0", first, a0, a1);
        end
    endtask

    task automatic test_tie();
        logic [2:0] busy_seq;
        apply_reset();
        drive_m(0, 1'b1, 1'b1, 1'b0, 32'hA0, 32'h0, 4'hF, 3'b000);
        drive_m(1, 1'b1, 1'b1, 1'b1, 32'hB0, 32'h5, 4'hF, 3'b000);
        for (int k = 0; k < 8; k++) begin
            drive_s(k == 1 || k == 2 || k == 6, 1'b0, 1'b0, 32'h0);
            if (k == 3) drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
            if (k == 7) drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
            cycle(oc, ec, od, ed);
            checks++;
            if ({oc, od} !== {ec, ed}) begin
                errors++; $display("FAIL tie k=%0d ctl act=%h exp=%h data act=%h exp=%h", k, oc, ec, od, ed);
            end
            if (k == 1 && od[136:105] !== 32'hA0) begin
                errors++; $display("FAIL tie_first act=%h exp=%h", od[136:105], 32'hA0);
            end
            if (k >= 3 && k <= 5) busy_seq[k-3] = oc[B_BUSY];
            if (k == 5 && od[136:105] !== 32'hB0) begin
                errors++; $display("FAIL tie_second act=%h exp=%h", od[136:105], 32'hB0);
            end
        end
        checks += 3;
        if (busy_seq !== 3'b101) begin
            errors++; $display("FAIL tie_idle_gap busy act=%b exp=101", busy_seq);
        end
    endtask

    task automatic test_rr();
        drive_m(1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 4'hF, 3'b010);
        for (int k = 0; k < 9; k++) begin
            if (k == 1) drive_m(0, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF, 3'b000);
            drive_s(k == 1 || k == 2 || k == 6, 1'b0, 1'b0, 32'h0);
            if (k == 3) s1.cyc = 1'b0;
            if (k == 4) s1.cyc = 1'b1;
            if (k == 7) drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
            cycle(oc, ec, od, ed);
            checks++;
            if ({oc, od} !== {ec, ed}) begin
                errors++; $display("FAIL rr k=%0d ctl act=%h exp=%h data act=%h exp=%h", k, oc, ec, od, ed);
            end
            if (k == 5 && od[136:105] !== 32'h300) begin
                errors++; $display("FAIL rr_owner act=%h exp=%h", od[136:105], 32'h300);
            end
        end
        release_all();
        cycle(oc, ec, od, ed);
        cycle(oc, ec, od, ed);
        cycle(oc, ec, od, ed);
    endtask

    task automatic test_write_m1();
        logic [31:0] d;
        d = $urandom;
        drive_m(1, 1'b1, 1'b1, 1'b1, 32'h100, d, 4'b0011, 3'b000);
        for (int k = 0; k < 3; k++) begin
            drive_s(k == 1, 1'b0, 1'b0, 32'h0);
            if (k == 2) drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
            cycle(oc, ec, od, ed);
            checks++;
            if ({oc, od} !== {ec, ed}) begin
                errors++; $display("FAIL write_m1 k=%0d ctl act=%h exp=%h data act=%h exp=%h", k, oc, ec, od, ed);
            end
            if (k == 1 && {od[137:69]} !== {1'b1, 32'h100, d, 4'b0011}) begin
                errors++; $display("FAIL write_fields act=%h exp=%h", od[137:69], {1'b1, 32'h100, d, 4'b0011});
            end
        end
        cycle(oc, ec, od, ed);
    endtask

    task automatic test_late_ack();
        for (int k = 0; k < 3; k++) begin
            drive_s(1'b1, 1'b1, 1'b1, $urandom);
            cycle(oc, ec, od, ed);
            checks++;
            if (oc[14:9] !== 6'd0 || {oc, od} !== {ec, ed}) begin
                errors++; $display("FAIL late_ack ctl act=%h exp=%h data act=%h exp=%h", oc, ec, od, ed);
            end
        end
        drive_s(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_watchdog();
        int err_at = -1;
        logic cyc_at_err = 1'b1;
        drive_m(0, 1'b1, 1'b1, 1'b0, 32'h800, 32'h0, 4'hF, 3'b010);
        cycle(oc, ec, od, ed);
        for (int k = 1; k <= 20 && err_at < 0; k++) begin
            cycle(oc, ec, od, ed);
            checks++;
            if ({oc, od} !== {ec, ed}) begin
                errors++; $display("FAIL watchdog k=%0d ctl act=%h exp=%h data act=%h exp=%h", k, oc, ec, od, ed);
            end
            if (oc[B_S0ERR]) begin
                err_at = k; cyc_at_err = oc[B_MCYC];
            end
        end
        drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
        cycle(oc, ec, od, ed);
        checks++;
        if (err_at !== 16 || cyc_at_err !== 1'b0 || oc[7:0] !== 8'd1 || oc[B_BUSY] !== 1'b0) begin
            errors++; $display("FAIL watchdog_abort err_cycle=%0d cyc=%b abort_cnt=%0d busy=%b exp 16/0/1/0",
                               err_at, cyc_at_err, oc[7:0], oc[B_BUSY]);
        end
    endtask

    task automatic test_stb_hold();
        int err_at = -1;
        drive_m(1, 1'b1, 1'b0, 1'b0, 32'h900, 32'h0, 4'hF, 3'b000);
        for (int k = 0; k < 40; k++) begin
            cycle(oc, ec, od, ed);
            checks++;
            if ({oc, od} !== {ec, ed}) begin
                errors++; $display("FAIL stb_hold k=%0d ctl act=%h exp=%h data act=%h exp=%h", k, oc, ec, od, ed);
            end
        end
        s1.stb = 1'b1;
        for (int k = 1; k <= 20 && err_at < 0; k++) begin
            cycle(oc, ec, od, ed);
            if (oc[B_S1ERR]) err_at = k;
        end
        checks++;
        if (err_at !== 16) begin
            errors++; $display("FAIL stb_hold_abort err_cycle act=%0d exp=16", err_at);
        end
        release_all();
        cycle(oc, ec, od, ed);
    endtask

    task automatic test_reset_mid();
        drive_m(1, 1'b1, 1'b1, 1'b0, 32'hC00, 32'h0, 4'hF, 3'b010);
        drive_s(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(oc, ec, od, ed);
        cycle(oc, ec, od, ed);
        cycle(oc, ec, od, ed);
        rst_n = 1'b0;
        cycle(oc, ec, od, ed);
        checks++;
        if ({oc, od} !== {ec, ed}) begin
            errors++; $display("FAIL reset_mid_edge ctl act=%h exp=%h data act=%h exp=%h", oc, ec, od, ed);
        end
        rst_n = 1'b1;
        release_all();
        cycle(oc, ec, od, ed);
        checks++;
        if ({oc[B_MCYC], oc[B_BUSY], oc[7:0]} !== 10'd0) begin
            errors++; $display("FAIL reset_mid_after act=%h exp=0", {oc[B_MCYC], oc[B_BUSY], oc[7:0]});
        end
        drive_m(0, 1'b1, 1'b1, 1'b0, 32'hD00, 32'h0, 4'hF, 3'b000);
        drive_m(1, 1'b1, 1'b1, 1'b0, 32'hE00, 32'h0, 4'hF, 3'b000);
        cycle(oc, ec, od, ed);
        cycle(oc, ec, od, ed);
        checks++;
        if (od[136:105] !== 32'hD00 || {oc, od} !== {ec, ed}) begin
            errors++; $display("FAIL reset_mid_first_grant adr act=%h exp=%h", od[136:105], 32'hD00);
        end
        release_all();
        cycle(oc, ec, od, ed);
        cycle(oc, ec, od, ed);
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            if (!s0.cyc) s0.cyc = ($urandom_range(3) == 0);
            else         s0.cyc = ($urandom_range(7) != 0);
            if (!s1.cyc) s1.cyc = ($urandom_range(3) == 0);
            else         s1.cyc = ($urandom_range(7) != 0);
            s0.stb = s0.cyc & ($urandom_range(3) != 0);
            s1.stb = s1.cyc & ($urandom_range(3) != 0);
            s0.we = 1'($urandom); s0.adr = $urandom; s0.dat_ms = $urandom; s0.sel = 4'($urandom); s0.cti = 3'($urandom);
            s1.we = 1'($urandom); s1.adr = $urandom; s1.dat_ms = $urandom; s1.sel = 4'($urandom); s1.cti = 3'($urandom);
            drive_s($urandom_range(4) == 0, $urandom_range(15) == 0, $urandom_range(15) == 0, $urandom);
            cycle(oc, ec, od, ed);
            checks++;
            if ({oc, od} !== {ec, ed}) begin
                errors++; $display("FAIL random k=%0d ctl act=%h exp=%h data act=%h exp=%h", k, oc, ec, od, ed);
            end
        end
        release_all();
        cycle(oc, ec, od, ed);
        cycle(oc, ec, od, ed);
    endtask

    task automatic test_saturation();
        drive_m(0, 1'b1, 1'b1, 1'b0, 32'hF00, 32'h0, 4'hF, 3'b000);
        for (int k = 0; k < 4500; k++) begin
            cycle(oc, ec, od, ed);
            checks++;
            if ({oc, od} !== {ec, ed}) begin
                errors++; $display("FAIL saturation k=%0d ctl act=%h exp=%h data act=%h exp=%h", k, oc, ec, od, ed);
            end
        end
        checks++;
        if (oc[7:0] !== 8'd255) begin
            errors++; $display("FAIL saturation_final abort_cnt act=%0d exp=255", oc[7:0]);
        end
        release_all();
    endtask

    initial begin
        rst_n = 1'b0;
        release_all();
        apply_reset();
        test_reset();
        test_burst_m0();
        test_tie();
        test_rr();
        test_write_m1();
        test_late_ack();
        test_watchdog();
        test_stb_hold();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
